// File: rtl/aes_reseed_ctrl_pkg.sv
// ============================================================================
// Module      : aes_reseed_ctrl_pkg
// Description : Shared constants for the AES reseed-policy controller:
//               FSM state encodings and the PRNG seed width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_reseed_ctrl_pkg;

  // Width of the PRNG seed carried from the entropy source to the AES top.
  localparam int unsigned C_SEED_W = 80;

  // Controller FSM encoding.
  localparam int unsigned       C_STATE_W = 2;
  localparam logic [C_STATE_W-1:0] C_ST_INIT  = 2'd0;  // first seed after reset
  localparam logic [C_STATE_W-1:0] C_ST_RUN   = 2'd1;  // encryptions flowing
  localparam logic [C_STATE_W-1:0] C_ST_DRAIN = 2'd2;  // waiting for in-flight results
  localparam logic [C_STATE_W-1:0] C_ST_SEED  = 2'd3;  // offering a fresh seed

  // True in the two states where the seed path is open.
  function automatic logic state_is_seeding(input logic [C_STATE_W-1:0] s);
    return (s == C_ST_INIT) || (s == C_ST_SEED);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_reseed_ctrl_updown_cnt.sv
// ============================================================================
// Module      : aes_reseed_ctrl_updown_cnt
// Description : Up/down counter tracking encryptions in flight inside the
//               AES top. Increment and decrement in the same cycle hold.
// Ports       : clk      - clock
//               rst      - synchronous active-low reset (count -> 0)
//               inc_i    - one encryption accepted
//               dec_i    - one result returned
//               count_o  - current count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_reseed_ctrl_updown_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({inc_i, dec_i})
      2'b10:   count_d = count_q + WIDTH'(1);
      2'b01:   count_d = count_q - WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/aes_reseed_ctrl.sv
// ============================================================================
// Module      : aes_reseed_ctrl
// Description : Reseed-policy controller between the user input stream and
//               the masked AES top. Seeds the PRNG after reset, every
//               RESEED_PERIOD encryptions, and on force_reseed. In-flight
//               encryptions are drained before a seed is offered.
// Ports       : clk, rst (sync, active-low)
//               usr_in_valid/usr_in_ready     - user plaintext/key handshake
//               core_in_valid/core_in_ready   - AES top input handshake
//               core_out_valid/core_out_ready - AES top output (monitored)
//               seed_src_valid/ready/data     - entropy-source seed stream
//               core_seed_valid/ready, core_seed - AES top seed port
//               force_reseed                  - single-cycle reseed request
//               reseed_busy                   - high outside RUN
//               enc_count, reseed_count       - status counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_reseed_ctrl
  import aes_reseed_ctrl_pkg::*;
#(
  parameter int unsigned RESEED_PERIOD = 1024,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned OUT_W         = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                usr_in_valid,
  output logic                usr_in_ready,
  output logic                core_in_valid,
  input  logic                core_in_ready,
  input  logic                core_out_valid,
  input  logic                core_out_ready,
  input  logic                seed_src_valid,
  output logic                seed_src_ready,
  input  logic [C_SEED_W-1:0] seed_src_data,
  output logic                core_seed_valid,
  input  logic                core_seed_ready,
  output logic [C_SEED_W-1:0] core_seed,
  input  logic                force_reseed,
  output logic                reseed_busy,
  output logic [CNT_W-1:0]    enc_count,
  output logic [CNT_W-1:0]    reseed_count
);

  localparam logic [OUT_W-1:0] C_OUT_MAX  = '1;
  localparam logic [CNT_W:0]   C_PERIOD   = (CNT_W+1)'(RESEED_PERIOD);
  localparam bit               C_PERIODIC = (RESEED_PERIOD != 0);

  logic [C_STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]     enc_count_q, enc_count_d;
  logic [CNT_W-1:0]     reseed_count_q, reseed_count_d;
  logic                 pend_q, pend_d;

  logic [OUT_W-1:0]     w_outstanding;
  logic [CNT_W:0]       w_enc_next;
  logic                 w_acc, w_ret, w_full, w_seed_fire;
  logic                 w_period_hit, w_trigger, w_drained;

  // --------------------------------------------------------------------------
  // Handshake events and derived conditions
  // --------------------------------------------------------------------------
  assign w_acc       = core_in_valid & core_in_ready;
  assign w_ret       = core_out_valid & core_out_ready;
  assign w_seed_fire = core_seed_valid & core_seed_ready;
  assign w_full      = (w_outstanding == C_OUT_MAX);

  // One extra bit so the period compare cannot alias on counter wrap.
  assign w_enc_next   = {1'b0, enc_count_q} + (CNT_W+1)'(w_acc);
  assign w_period_hit = C_PERIODIC && (w_enc_next == C_PERIOD);
  assign w_trigger    = pend_q | force_reseed | w_period_hit;

  // The final result may return in the very cycle we leave DRAIN.
  assign w_drained = (w_outstanding == OUT_W'(w_ret));

  // Seed bus is a straight pass-through; only its handshake is gated.
  assign core_seed = seed_src_data;

  aes_reseed_ctrl_updown_cnt #(
    .WIDTH (OUT_W)
  ) u_outstanding (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (w_acc),
    .dec_i   (w_ret),
    .count_o (w_outstanding)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= C_ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_INIT:  if (w_seed_fire) state_d = C_ST_RUN;
      C_ST_RUN:   if (w_trigger)   state_d = C_ST_DRAIN;
      C_ST_DRAIN: if (w_drained)   state_d = C_ST_SEED;
      C_ST_SEED:  if (w_seed_fire) state_d = C_ST_RUN;
      default:                     state_d = C_ST_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Everything is held at its reset value while rst is low so
  // that no handshake can complete in the reset cycle, whatever the state.
  // --------------------------------------------------------------------------
  always_comb begin
    usr_in_ready    = 1'b0;
    core_in_valid   = 1'b0;
    core_seed_valid = 1'b0;
    seed_src_ready  = 1'b0;
    reseed_busy     = 1'b1;
    if (rst) begin
      case (state_q)
        C_ST_RUN: begin
          core_in_valid = usr_in_valid & ~w_full;
          usr_in_ready  = core_in_ready & ~w_full;
          reseed_busy   = 1'b0;
        end
        C_ST_INIT, C_ST_SEED: begin
          core_seed_valid = seed_src_valid;
          seed_src_ready  = core_seed_ready;
        end
        default: begin
          // DRAIN: input held low so the AES top sees ~in_valid while idle.
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status counters and pending-request flag
  // --------------------------------------------------------------------------
  always_comb begin
    enc_count_d    = enc_count_q;
    reseed_count_d = reseed_count_q;
    pend_d         = pend_q;

    // acc is only possible in RUN; the trigger-cycle accept is still counted.
    if (w_acc) begin
      enc_count_d = w_enc_next[CNT_W-1:0];
    end

    // seed_fire is only possible in INIT/SEED.
    if (w_seed_fire) begin
      enc_count_d    = '0;
      reseed_count_d = reseed_count_q + CNT_W'(1);
    end

    // A request arriving while a seed is already being offered is absorbed
    // by that reseed; otherwise remember it until the next SEED completes.
    if (state_q == C_ST_SEED && w_seed_fire) begin
      pend_d = 1'b0;
    end else if (force_reseed && !state_is_seeding(state_q)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      enc_count_q    <= '0;
      reseed_count_q <= '0;
      pend_q         <= 1'b0;
    end else begin
      enc_count_q    <= enc_count_d;
      reseed_count_q <= reseed_count_d;
      pend_q         <= pend_d;
    end
  end

  assign enc_count    = enc_count_q;
  assign reseed_count = reseed_count_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_reseed_ctrl.sv
// ============================================================================
// Module      : tb_aes_reseed_ctrl
// Description : Directed self-checking bench for aes_reseed_ctrl with
//               RESEED_PERIOD=4, CNT_W=16, OUT_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_reseed_ctrl;

  localparam int unsigned RESEED_PERIOD = 4;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned OUT_W         = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              usr_in_valid, usr_in_ready;
  logic              core_in_valid, core_in_ready;
  logic              core_out_valid, core_out_ready;
  logic              seed_src_valid, seed_src_ready;
  logic [79:0]       seed_src_data;
  logic              core_seed_valid, core_seed_ready;
  logic [79:0]       core_seed;
  logic              force_reseed;
  logic              reseed_busy;
  logic [CNT_W-1:0]  enc_count, reseed_count;

  int n_tests = 0;
  int n_fail  = 0;
  int accepts;

  aes_reseed_ctrl #(
    .RESEED_PERIOD (RESEED_PERIOD),
    .CNT_W         (CNT_W),
    .OUT_W         (OUT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .usr_in_valid    (usr_in_valid),
    .usr_in_ready    (usr_in_ready),
    .core_in_valid   (core_in_valid),
    .core_in_ready   (core_in_ready),
    .core_out_valid  (core_out_valid),
    .core_out_ready  (core_out_ready),
    .seed_src_valid  (seed_src_valid),
    .seed_src_ready  (seed_src_ready),
    .seed_src_data   (seed_src_data),
    .core_seed_valid (core_seed_valid),
    .core_seed_ready (core_seed_ready),
    .core_seed       (core_seed),
    .force_reseed    (force_reseed),
    .reseed_busy     (reseed_busy),
    .enc_count       (enc_count),
    .reseed_count    (reseed_count)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs changed after this apply to
  // the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b0;
    usr_in_valid   = 1'b0;
    core_in_ready  = 1'b1;
    core_out_valid = 1'b0;
    core_out_ready = 1'b1;
    seed_src_valid = 1'b0;
    seed_src_data  = 80'h0123_4567_89AB_CDEF_F00D;
    core_seed_ready = 1'b0;
    force_reseed   = 1'b0;

    // ---------------- reset ----------------
    tick(); tick();
    chk("rst_busy",        80'(reseed_busy),   80'd1);
    chk("rst_usr_ready",   80'(usr_in_ready),  80'd0);
    rst = 1'b1;
    settle();
    chk("rst_enc_count",   80'(enc_count),     80'd0);
    chk("rst_reseed_cnt",  80'(reseed_count),  80'd0);
    chk("rst_core_valid",  80'(core_in_valid), 80'd0);

    // ---------------- 1. initial seed ----------------
    seed_src_valid = 1'b1;
    settle();
    chk("t1_seed_valid",   80'(core_seed_valid), 80'd1);
    chk("t1_src_ready_lo", 80'(seed_src_ready),  80'd0);
    chk("t1_seed_pass",    core_seed, 80'h0123_4567_89AB_CDEF_F00D);
    tick(); tick(); tick();
    core_seed_ready = 1'b1;              // pulse at cycle 5
    settle();
    chk("t1_src_ready_hi", 80'(seed_src_ready), 80'd1);
    tick();
    core_seed_ready = 1'b0;
    seed_src_valid  = 1'b0;
    settle();
    chk("t1_reseed_cnt",   80'(reseed_count), 80'd1);
    chk("t1_busy_lo",      80'(reseed_busy),  80'd0);
    chk("t1_usr_rdy_hi",   80'(usr_in_ready), 80'd1);
    core_in_ready = 1'b0;
    settle();
    chk("t1_usr_rdy_lo",   80'(usr_in_ready), 80'd0);

    // ---------------- 2. periodic reseed after 4 accepts ----------------
    core_in_ready = 1'b1;
    usr_in_valid  = 1'b1;
    settle();
    chk("t2_core_valid",   80'(core_in_valid), 80'd1);
    tick();                               // acc 1, outstanding 1
    tick();                               // acc 2, outstanding 2
    core_out_valid = 1'b1;
    tick();                               // acc 3 + ret, outstanding 2
    core_out_valid = 1'b0;
    settle();
    chk("t2_usr_rdy_4th",  80'(usr_in_ready), 80'd1);
    chk("t2_enc_3",        80'(enc_count),    80'd3);
    tick();                               // acc 4 -> trigger, outstanding 3
    settle();
    chk("t2_enc_4",        80'(enc_count),     80'd4);
    chk("t2_gated",        80'(core_in_valid), 80'd0);
    chk("t2_drain_busy",   80'(reseed_busy),   80'd1);
    usr_in_valid = 1'b0;

    // ---------------- 3. drain with seed source already valid ----------------
    seed_src_valid = 1'b1;
    settle();
    chk("t3_no_seed_drain", 80'(core_seed_valid), 80'd0);
    core_out_valid = 1'b1;
    tick();                               // outstanding 2
    tick();                               // outstanding 1
    core_seed_ready = 1'b1;
    settle();
    chk("t3_no_early_rdy", 80'(seed_src_ready),  80'd0);
    chk("t3_still_drain",  80'(core_seed_valid), 80'd0);
    tick();                               // final ret, leave DRAIN
    core_out_valid = 1'b0;
    settle();
    chk("t3_seed_now",     80'(core_seed_valid), 80'd1);
    chk("t3_src_rdy_seed", 80'(seed_src_ready),  80'd1);
    tick();
    core_seed_ready = 1'b0;
    seed_src_valid  = 1'b0;
    settle();
    chk("t3_reseed_2",     80'(reseed_count), 80'd2);
    chk("t3_enc_clr",      80'(enc_count),    80'd0);
    chk("t3_run",          80'(reseed_busy),  80'd0);

    // ---------------- 4. force with periodic trigger, and in SEED ----------------
    usr_in_valid = 1'b1;
    tick();                               // acc 1, outstanding 1
    core_out_valid = 1'b1;
    tick(); tick();                       // acc 2,3 with ret, outstanding 1
    force_reseed = 1'b1;
    tick();                               // acc 4 + ret + force, outstanding 1
    force_reseed = 1'b0;
    usr_in_valid = 1'b0;
    settle();
    chk("t4_enc_4",        80'(enc_count),   80'd4);
    chk("t4_drain",        80'(reseed_busy), 80'd1);
    tick();                               // last ret -> SEED
    core_out_valid = 1'b0;
    force_reseed   = 1'b1;
    seed_src_valid = 1'b1;
    settle();
    chk("t4_in_seed",      80'(core_seed_valid), 80'd1);
    tick();
    force_reseed    = 1'b0;
    core_seed_ready = 1'b1;
    tick();
    core_seed_ready = 1'b0;
    seed_src_valid  = 1'b0;
    settle();
    chk("t4_reseed_3",     80'(reseed_count), 80'd3);
    tick(); tick(); tick();
    chk("t4_no_dup_busy",  80'(reseed_busy),  80'd0);
    chk("t4_no_dup_cnt",   80'(reseed_count), 80'd3);

    // ---------------- 5. stalled sink limits in-flight to 3 ----------------
    core_out_ready = 1'b0;
    core_out_valid = 1'b1;
    usr_in_valid   = 1'b1;
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (core_in_valid && core_in_ready) accepts++;
      tick();
    end
    chk("t5_accepts",      80'(accepts),      80'd3);
    chk("t5_usr_rdy_full", 80'(usr_in_ready), 80'd0);
    chk("t5_enc_3",        80'(enc_count),    80'd3);

    // ---------------- 6. reset during DRAIN ----------------
    usr_in_valid = 1'b0;
    force_reseed = 1'b1;
    tick();                               // -> DRAIN, outstanding 3
    force_reseed   = 1'b0;
    core_out_ready = 1'b1;
    tick();                               // one ret, outstanding 2
    core_out_ready = 1'b0;
    settle();
    chk("t6_drain_busy",   80'(reseed_busy), 80'd1);
    rst             = 1'b0;
    seed_src_valid  = 1'b1;
    core_seed_ready = 1'b1;
    settle();
    chk("t6_rst_no_src_rdy", 80'(seed_src_ready),  80'd0);
    chk("t6_rst_no_seed",    80'(core_seed_valid), 80'd0);
    tick();
    rst             = 1'b1;
    seed_src_valid  = 1'b0;
    core_seed_ready = 1'b0;
    usr_in_valid    = 1'b1;
    core_out_valid  = 1'b0;
    settle();
    chk("t6_init_busy",    80'(reseed_busy),   80'd1);
    chk("t6_reseed_0",     80'(reseed_count),  80'd0);
    chk("t6_enc_0",        80'(enc_count),     80'd0);
    chk("t6_in_gated",     80'(core_in_valid), 80'd0);
    // Reseed, then confirm the in-flight counter restarted from zero.
    seed_src_valid  = 1'b1;
    core_seed_ready = 1'b1;
    tick();
    seed_src_valid  = 1'b0;
    core_seed_ready = 1'b0;
    settle();
    chk("t6_reseed_1",     80'(reseed_count), 80'd1);
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (core_in_valid && core_in_ready) accepts++;
      tick();
    end
    chk("t6_accepts_3",    80'(accepts), 80'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
